// File: rtl/spi_slave_param.sv
// Purpose: SPI slave oversampled in the CLK domain, parameterised word width, CPOL/CPHA and synchroniser depth.
// Latency: pins seen SYNC_STAGES CLK late; RX_VALID one CLK after the DW-th sample edge; MISO one CLK after the TX shift register.
// Backpressure: none toward the master; TX_LOAD ignored while TX_READY=0, empty holding register at a word boundary sends all-ones with TX_UNDERRUN.
module spi_slave_param #(
  parameter int DW          = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          SCK,
  input  logic          MOSI,
  input  logic          CS,
  output logic          MISO,
  input  logic [DW-1:0] TX_DATA,
  input  logic          TX_LOAD,
  output logic          TX_READY,
  output logic [DW-1:0] RX_DATA,
  output logic          RX_VALID,
  output logic          FRAME_DONE,
  output logic          TX_UNDERRUN,
  output logic [1:0]    STATE
);

  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_s, cs_s, mosi_s, sck_prev;
  logic                   sck_rise, sck_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;
  logic                   frame_start, frame_end, sample_en, shift_en;
  logic                   tx_boundary;
  logic [CW-1:0]          bit_cnt;
  logic [DW-1:0]          rx_shift, rx_word;
  logic [DW-1:0]          tx_shift, tx_hold;
  logic                   tx_full;

  // Equal-depth synchronisers keep SCK, CS and MOSI aligned to each other;
  // CS resets low so a frame already in progress cannot be entered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign lead_edge   = (CPOL == 0) ? sck_rise : sck_fall;
  assign trail_edge  = (CPOL == 0) ? sck_fall : sck_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus frame strobes; SCK edges only count while the frame is open.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_s) state_nxt = ARMED;
      end
      ARMED: begin
        if (!cs_s) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_nxt = ARMED;
          frame_end = 1'b1;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign STATE = state;

  // A shift edge with the bit counter at zero starts a new word; CPHA=0 also
  // needs the first bit on MISO before any SCK edge, so frame start is a boundary.
  assign tx_boundary = (frame_start && (CPHA == 0)) || (shift_en && (bit_cnt == '0));

  assign rx_word = {rx_shift[DW-2:0], mosi_s};

  // Receive path: MSB-first shift, word strobe on the DW-th sample, partial words dropped at frame end.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      RX_VALID   <= 1'b0;
      FRAME_DONE <= frame_end;
      if (frame_end) begin
        bit_cnt <= '0;
      end else if (sample_en) begin
        rx_shift <= rx_word;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          RX_DATA  <= rx_word;
          RX_VALID <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // Transmit path: holding register feeds the shift register at word boundaries;
  // a load arriving exactly at a boundary with nothing held bypasses the holding register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      TX_UNDERRUN <= 1'b0;
    end else begin
      TX_UNDERRUN <= 1'b0;
      if (tx_boundary) begin
        if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
        end else if (TX_LOAD) begin
          tx_shift <= TX_DATA;
        end else begin
          tx_shift    <= '1;
          TX_UNDERRUN <= 1'b1;
        end
      end else begin
        if (shift_en) tx_shift <= {tx_shift[DW-2:0], 1'b1};
        if (TX_LOAD && !tx_full) begin
          tx_hold <= TX_DATA;
          tx_full <= 1'b1;
        end
      end
    end
  end

  assign TX_READY = ~tx_full;

  // Registered MISO: idles high outside a frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      MISO <= 1'b1;
    end else begin
      MISO <= (state == ACTIVE) ? tx_shift[DW-1] : 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Purpose: directed bench for spi_slave_param, one instance in mode 0 (DW=8) and one in mode 3 (DW=16).
// Latency: SCK half-period of 8 CLK, inputs driven on the falling CLK edge.
// Backpressure: n/a.
module tb_spi_slave_param;

  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        mosi;
  logic        sck_a, cs_a, miso_a, tx_load_a, tx_ready_a, rx_valid_a, frame_done_a, tx_underrun_a;
  logic [7:0]  tx_data_a, rx_data_a;
  logic [1:0]  state_a;
  logic        sck_b, cs_b, miso_b, tx_load_b, tx_ready_b, rx_valid_b, frame_done_b, tx_underrun_b;
  logic [15:0] tx_data_b, rx_data_b;
  logic [1:0]  state_b;

  spi_slave_param #(.DW(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .nRST(nrst), .SCK(sck_a), .MOSI(mosi), .CS(cs_a), .MISO(miso_a),
    .TX_DATA(tx_data_a), .TX_LOAD(tx_load_a), .TX_READY(tx_ready_a),
    .RX_DATA(rx_data_a), .RX_VALID(rx_valid_a), .FRAME_DONE(frame_done_a),
    .TX_UNDERRUN(tx_underrun_a), .STATE(state_a)
  );

  spi_slave_param #(.DW(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) dut_b (
    .CLK(clk), .nRST(nrst), .SCK(sck_b), .MOSI(mosi), .CS(cs_b), .MISO(miso_b),
    .TX_DATA(tx_data_b), .TX_LOAD(tx_load_b), .TX_READY(tx_ready_b),
    .RX_DATA(rx_data_b), .RX_VALID(rx_valid_b), .FRAME_DONE(frame_done_b),
    .TX_UNDERRUN(tx_underrun_b), .STATE(state_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;
  logic [31:0] mosi_w [0:3];
  logic [31:0] miso_w [0:3];
  int und_start, und_snap;

  // Pulse counters and received-word log, sampled away from the active edge.
  int rxv_a = 0, fd_a = 0, und_a = 0, fd_b = 0, und_b = 0;
  logic [15:0] rx_q_b [$];
  always @(negedge clk) begin
    if (rx_valid_a)    rxv_a++;
    if (frame_done_a)  fd_a++;
    if (tx_underrun_a) und_a++;
    if (frame_done_b)  fd_b++;
    if (tx_underrun_b) und_b++;
    if (rx_valid_b)    rx_q_b.push_back(rx_data_b);
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input logic v);
    if (sel == 0) sck_a = v; else sck_b = v;
  endtask

  task automatic set_cs(input logic v);
    if (sel == 0) cs_a = v; else cs_b = v;
  endtask

  function automatic logic get_miso();
    return (sel == 0) ? miso_a : miso_b;
  endfunction

  function automatic logic mosi_bit(input int i, input int dw);
    logic [31:0] w;
    w = mosi_w[i / dw];
    return w[dw - 1 - (i % dw)];
  endfunction

  // Master model: nbits SCK cycles from mosi_w, MISO bits collected into miso_w.
  task automatic spi_bits(input int nbits, input bit release_cs);
    int dw;
    bit cpol, cpha;
    dw   = (sel == 0) ? 8 : 16;
    cpol = (sel != 0);
    cpha = (sel != 0);
    for (int w = 0; w < 4; w++) miso_w[w] = '0;
    set_cs(1'b0);
    if (!cpha) mosi = mosi_bit(0, dw);
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) und_start = (sel == 0) ? und_a : und_b;
      if (cpha) mosi = mosi_bit(i, dw);
      if (!cpha) miso_w[i / dw] = {miso_w[i / dw][30:0], get_miso()};
      set_sck(!cpol);
      tick(H);
      if (i == nbits - 1) und_snap = (sel == 0) ? und_a : und_b;
      if (cpha) miso_w[i / dw] = {miso_w[i / dw][30:0], get_miso()};
      set_sck(cpol);
      if (!cpha && (i + 1 < nbits)) mosi = mosi_bit(i + 1, dw);
      tick(H);
    end
    if (release_cs) begin
      set_cs(1'b1);
      tick(2 * H);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; mosi = 1'b0;
    sck_a = 1'b0; cs_a = 1'b1; tx_load_a = 1'b0; tx_data_a = '0;
    sck_b = 1'b1; cs_b = 1'b1; tx_load_b = 1'b0; tx_data_b = '0;
    tick(3);
    n_cmp++; if ({state_a, miso_a, tx_ready_a, rx_data_a, rx_valid_a, frame_done_a, tx_underrun_a} !== {2'd0, 1'b1, 1'b1, 8'h00, 3'b000}) begin n_bad++; $display("FAIL reset_a: got st=%0d miso=%b rdy=%b rx=%h v=%b fd=%b u=%b want 0/1/1/00/0/0/0", state_a, miso_a, tx_ready_a, rx_data_a, rx_valid_a, frame_done_a, tx_underrun_a); end
    n_cmp++; if ({state_b, miso_b, tx_ready_b, rx_data_b, rx_valid_b, frame_done_b, tx_underrun_b} !== {2'd0, 1'b1, 1'b1, 16'h0000, 3'b000}) begin n_bad++; $display("FAIL reset_b: got st=%0d miso=%b rdy=%b rx=%h v=%b fd=%b u=%b want 0/1/1/0000/0/0/0", state_b, miso_b, tx_ready_b, rx_data_b, rx_valid_b, frame_done_b, tx_underrun_b); end
    nrst = 1'b1;
    tick(10);
    n_cmp++; if (state_a !== 2'd1) begin n_bad++; $display("FAIL armed_a: got %0d want 1", state_a); end
    n_cmp++; if (state_b !== 2'd1) begin n_bad++; $display("FAIL armed_b: got %0d want 1", state_b); end
  endtask

  task automatic test_mode0_basic();
    int rv0, fd0;
    sel = 0; rv0 = rxv_a; fd0 = fd_a;
    tx_data_a = 8'hA5; tx_load_a = 1'b1; tick(1); tx_load_a = 1'b0; tick(1);
    n_cmp++; if (tx_ready_a !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %b want 0", tx_ready_a); end
    mosi_w[0] = 32'h3C;
    spi_bits(8, 1);
    n_cmp++; if (miso_w[0][7:0] !== 8'hA5) begin n_bad++; $display("FAIL basic_miso: got %h want a5", miso_w[0][7:0]); end
    n_cmp++; if (rx_data_a !== 8'h3C) begin n_bad++; $display("FAIL basic_rx: got %h want 3c", rx_data_a); end
    n_cmp++; if (rxv_a - rv0 !== 1) begin n_bad++; $display("FAIL basic_rx_valid_count: got %0d want 1", rxv_a - rv0); end
    n_cmp++; if (fd_a - fd0 !== 1) begin n_bad++; $display("FAIL basic_frame_done_count: got %0d want 1", fd_a - fd0); end
    n_cmp++; if (tx_ready_a !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b want 1", tx_ready_a); end
  endtask

  task automatic test_underrun();
    int u0;
    sel = 0; u0 = und_a;
    mosi_w[0] = 32'h5A;
    spi_bits(8, 1);
    n_cmp++; if (miso_w[0][7:0] !== 8'hFF) begin n_bad++; $display("FAIL underrun_miso: got %h want ff", miso_w[0][7:0]); end
    n_cmp++; if (und_start - u0 !== 1) begin n_bad++; $display("FAIL underrun_at_start: got %0d pulses want 1", und_start - u0); end
    n_cmp++; if (und_snap - u0 !== 1) begin n_bad++; $display("FAIL underrun_in_word: got %0d pulses want 1", und_snap - u0); end
    n_cmp++; if (rx_data_a !== 8'h5A) begin n_bad++; $display("FAIL underrun_rx: got %h want 5a", rx_data_a); end
  endtask

  task automatic test_partial();
    int rv0, fd0;
    sel = 0; rv0 = rxv_a; fd0 = fd_a;
    mosi_w[0] = 32'hF0;
    spi_bits(5, 1);
    n_cmp++; if (rxv_a - rv0 !== 0) begin n_bad++; $display("FAIL partial_no_valid: got %0d want 0", rxv_a - rv0); end
    n_cmp++; if (fd_a - fd0 !== 1) begin n_bad++; $display("FAIL partial_frame_done: got %0d want 1", fd_a - fd0); end
    n_cmp++; if (rx_data_a !== 8'h5A) begin n_bad++; $display("FAIL partial_rx_hold: got %h want 5a", rx_data_a); end
    rv0 = rxv_a;
    mosi_w[0] = 32'h81;
    spi_bits(8, 1);
    n_cmp++; if (rx_data_a !== 8'h81) begin n_bad++; $display("FAIL partial_next_rx: got %h want 81", rx_data_a); end
    n_cmp++; if (rxv_a - rv0 !== 1) begin n_bad++; $display("FAIL partial_next_valid: got %0d want 1", rxv_a - rv0); end
  endtask

  task automatic test_tx_load_ignored();
    sel = 0;
    tx_data_a = 8'hAA; tx_load_a = 1'b1; tick(1);
    tx_data_a = 8'h55; tick(1);
    tx_load_a = 1'b0; tick(1);
    n_cmp++; if (tx_ready_a !== 1'b0) begin n_bad++; $display("FAIL ignored_ready: got %b want 0", tx_ready_a); end
    mosi_w[0] = 32'h00;
    spi_bits(8, 1);
    n_cmp++; if (miso_w[0][7:0] !== 8'hAA) begin n_bad++; $display("FAIL ignored_miso: got %h want aa", miso_w[0][7:0]); end
  endtask

  task automatic test_back_to_back();
    int fd0, u0, q0;
    sel = 1; fd0 = fd_b; u0 = und_b; q0 = rx_q_b.size();
    tx_data_b = 16'h1234; tx_load_b = 1'b1; tick(1); tx_load_b = 1'b0; tick(1);
    n_cmp++; if (tx_ready_b !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop: got %b want 0", tx_ready_b); end
    mosi_w[0] = 32'hCAFE; mosi_w[1] = 32'h0F0F;
    fork
      spi_bits(32, 1);
      begin
        tick(9 * H);
        n_cmp++; if (tx_ready_b !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_mid_word: got %b want 1", tx_ready_b); end
        tx_data_b = 16'hBEEF; tx_load_b = 1'b1; tick(1); tx_load_b = 1'b0; tick(2);
        n_cmp++; if (tx_ready_b !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_second: got %b want 0", tx_ready_b); end
      end
    join
    n_cmp++; if (miso_w[0][15:0] !== 16'h1234) begin n_bad++; $display("FAIL b2b_miso0: got %h want 1234", miso_w[0][15:0]); end
    n_cmp++; if (miso_w[1][15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL b2b_miso1: got %h want beef", miso_w[1][15:0]); end
    n_cmp++; if (rx_q_b.size() - q0 !== 2) begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q_b.size() - q0); end
    if (rx_q_b.size() - q0 >= 2) begin
      n_cmp++; if (rx_q_b[q0] !== 16'hCAFE) begin n_bad++; $display("FAIL b2b_rx0: got %h want cafe", rx_q_b[q0]); end
      n_cmp++; if (rx_q_b[q0 + 1] !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_rx1: got %h want 0f0f", rx_q_b[q0 + 1]); end
    end
    n_cmp++; if (und_b - u0 !== 0) begin n_bad++; $display("FAIL b2b_no_underrun: got %0d want 0", und_b - u0); end
    n_cmp++; if (fd_b - fd0 !== 1) begin n_bad++; $display("FAIL b2b_frame_done: got %0d want 1", fd_b - fd0); end
  endtask

  task automatic test_reset_mid_frame();
    int rv0, fd0;
    bit saw_active;
    sel = 0; rv0 = rxv_a; fd0 = fd_a; saw_active = 1'b0;
    mosi_w[0] = 32'hE0;
    spi_bits(3, 0);
    n_cmp++; if (state_a !== 2'd2) begin n_bad++; $display("FAIL midrst_active_before: got %0d want 2", state_a); end
    nrst = 1'b0;
    tick(2);
    n_cmp++; if ({state_a, miso_a, tx_ready_a, rx_data_a, rx_valid_a, frame_done_a, tx_underrun_a} !== {2'd0, 1'b1, 1'b1, 8'h00, 3'b000}) begin n_bad++; $display("FAIL midrst_outputs: got st=%0d miso=%b rdy=%b rx=%h v=%b fd=%b u=%b want 0/1/1/00/0/0/0", state_a, miso_a, tx_ready_a, rx_data_a, rx_valid_a, frame_done_a, tx_underrun_a); end
    nrst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_sck(k % 2 == 0);
      tick(H);
      if (state_a == 2'd2) saw_active = 1'b1;
    end
    n_cmp++; if (saw_active !== 1'b0) begin n_bad++; $display("FAIL midrst_no_active: got active=%b want 0", saw_active); end
    n_cmp++; if (state_a !== 2'd0) begin n_bad++; $display("FAIL midrst_idle: got %0d want 0", state_a); end
    n_cmp++; if ((rxv_a - rv0) + (fd_a - fd0) !== 0) begin n_bad++; $display("FAIL midrst_no_pulses: got valid=%0d done=%0d want 0/0", rxv_a - rv0, fd_a - fd0); end
    set_cs(1'b1); tick(H);
    n_cmp++; if (state_a !== 2'd1) begin n_bad++; $display("FAIL midrst_armed: got %0d want 1", state_a); end
    set_cs(1'b0); tick(H);
    n_cmp++; if (state_a !== 2'd2) begin n_bad++; $display("FAIL midrst_reactive: got %0d want 2", state_a); end
    set_cs(1'b1); tick(2 * H);
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_underrun();
    test_partial();
    test_tx_load_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
